// File: rtl/fc_seq.sv
// fc_seq: sequencer for the fully-connected output layer of the LSTM decoder.
//
// Accepts one hidden vector h_t per frame and walks the neuron (o) by
// hidden-element (h) loop. For each step it emits hidden-buffer and weight-ROM
// read addresses, then one cycle later the operand strobes that go to the MAC
// pipeline. Each biased neuron result that comes back is written to the output
// buffer in arrival order. Issue is throttled by a credit limit (MAX_OUT) on
// neurons that have started issuing but whose result has not yet returned.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   frame_valid         pulse: h_t is complete in the hidden buffer
//   frame_ready         high while idle and able to take a frame
//   ht_rd_addr          hidden buffer read address (h)
//   w_rd_addr           weight ROM read address (o*hidden_size + h)
//   rd_en               read strobe for the hidden buffer and weight ROM
//   mac_valid/first/last  rd_en, (h==0), (h==last) delayed one cycle
//   acc_valid, acc_data one neuron result from the MAC datapath
//   out_we, out_addr, out_data  output buffer write port
//   busy, done, err     status; err is sticky until the next frame is accepted
module fc_seq #(
    parameter int QZ          = 24,
    parameter int output_size = 96,
    parameter int hidden_size = 512,
    parameter int MAX_OUT     = 2,
    parameter int OS_W        = $clog2(output_size) + 1,
    parameter int HS_W        = $clog2(hidden_size) + 1,
    parameter int WA_W        = $clog2(output_size * hidden_size)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            frame_valid,
    output logic            frame_ready,
    output logic [HS_W-1:0] ht_rd_addr,
    output logic [WA_W-1:0] w_rd_addr,
    output logic            rd_en,
    output logic            mac_valid,
    output logic            mac_first,
    output logic            mac_last,
    input  logic            acc_valid,
    input  logic [QZ-1:0]   acc_data,
    output logic            out_we,
    output logic [OS_W-1:0] out_addr,
    output logic [QZ-1:0]   out_data,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam int OC_W = $clog2(MAX_OUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t          state, state_nxt;
    logic [HS_W-1:0] h;
    logic [OS_W-1:0] o;
    logic [OS_W-1:0] r;
    logic [OC_W-1:0] outst;
    logic [WA_W-1:0] w_base;    // o*hidden_size, kept as a running sum

    logic h_last, o_last, start, issue, acc_ok, acc_bad;

    assign h_last = (h == HS_W'(hidden_size - 1));
    assign o_last = (o == OS_W'(output_size - 1));
    assign start  = (state == S_IDLE) && frame_valid;

    // Only the first element of a neuron consumes a credit; once a neuron has
    // started, the rest of its elements issue back to back.
    assign issue  = (state == S_ISSUE) && ((h != '0) || (outst < OC_W'(MAX_OUT)));

    // A result is only expected while a frame is active, something is
    // outstanding and the frame still has results to collect.
    assign acc_ok  = acc_valid && (state != S_IDLE) && (outst != '0) &&
                     (r < OS_W'(output_size));
    assign acc_bad = acc_valid && !acc_ok;

    assign ht_rd_addr = h;
    assign w_rd_addr  = w_base + WA_W'(h);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        rd_en       = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        frame_ready = 1'b0;
        case (state)
            S_IDLE: begin
                busy        = 1'b0;
                frame_ready = !rst;
                if (frame_valid) state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                rd_en = issue;
                if (issue && h_last && o_last) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (out_we && (out_addr == OS_W'(output_size - 1))) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h         <= '0;
            o         <= '0;
            r         <= '0;
            outst     <= '0;
            w_base    <= '0;
            mac_valid <= 1'b0;
            mac_first <= 1'b0;
            mac_last  <= 1'b0;
            out_we    <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            err       <= 1'b0;
        end else begin
            // Strobes line up with the registered RAM/ROM read data.
            mac_valid <= issue;
            mac_first <= issue && (h == '0);
            mac_last  <= issue && h_last;

            out_we <= acc_ok;
            if (acc_ok) begin
                out_addr <= r;
                out_data <= acc_data;
            end

            if (start) begin
                h      <= '0;
                o      <= '0;
                w_base <= '0;
            end else if (issue) begin
                if (h_last) begin
                    h      <= '0;
                    o      <= o + 1'b1;
                    w_base <= w_base + WA_W'(hidden_size);
                end else begin
                    h <= h + 1'b1;
                end
            end

            if (start) begin
                r     <= '0;
                outst <= '0;
            end else begin
                if (acc_ok) r <= r + 1'b1;
                // A credit taken and returned in the same cycle cancel out.
                case ({issue && (h == '0), acc_ok})
                    2'b10:   outst <= outst + 1'b1;
                    2'b01:   outst <= outst - 1'b1;
                    default: outst <= outst;
                endcase
            end

            if (start)        err <= 1'b0;
            else if (acc_bad) err <= 1'b1;
        end
    end

endmodule

// File: doc/fc_seq.md
# fc_seq

Sequencer for the fully-connected output layer of the LSTM decoder. It accepts one completed hidden vector h_t per frame and walks the output-neuron × hidden-element loop, generating hidden-buffer and weight-ROM read addresses. It drives operand-valid/first/last strobes to the pipelined multiply-accumulate datapath and collects one biased result per output neuron into the output buffer. Issue is throttled by a credit limit on outstanding, unreturned neuron results.

## Interface
- QZ, 24, result data width
- output_size, 96, output neurons per frame
- hidden_size, 512, hidden elements per neuron
- MAX_OUT, 2, max neurons issued but not yet returned (≥1)
- OS_W, $clog2(output_size)+1, output index width
- HS_W, $clog2(hidden_size)+1, hidden index width
- WA_W, $clog2(output_size*hidden_size), weight ROM address width

- clk  in  1  single clock, all logic rising edge
- rst  in  1  asynchronous, active-high reset
- frame_valid  in  1  pulse: h_t fully written to hidden buffer
- frame_ready  out  1  high in IDLE only
- ht_rd_addr  out  HS_W  hidden buffer read address (h)
- w_rd_addr  out  WA_W  weight ROM address = o*hidden_size + h
- rd_en  out  1  read strobe for hidden buffer and weight ROM
- mac_valid  out  1  rd_en delayed 1 cycle (aligned with registered RAM/ROM data)
- mac_first  out  1  with mac_valid, h==0 (clear accumulator)
- mac_last  out  1  with mac_valid, h==hidden_size-1
- acc_valid  in  1  one neuron result (bias added) available
- acc_data  in  QZ  neuron result
- out_we  out  1  output buffer write
- out_addr  out  OS_W  neuron index r of written result
- out_data  out  QZ  acc_data registered
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse, frame complete
- err  out  1  sticky: unexpected acc_valid; cleared on frame accept

## Operation
- Counters: h (0..hidden_size-1), o (0..output_size-1), r (results received), outst (0..MAX_OUT).
- States:
  - IDLE: frame_ready=1. On frame_valid: h=o=r=outst=0, err=0, go to ISSUE.
  - ISSUE: issue permitted when h≠0 or outst<MAX_OUT. Permitted cycle: rd_en=1, addresses from current h,o; h++; at h==hidden_size-1, h wraps to 0 and o++. Issuing h==0 increments outst. Issuing (o,h)=(output_size-1,hidden_size-1) goes to DRAIN. Not permitted: rd_en=0, counters hold.
  - DRAIN: no issue. Go to DONE on the cycle out_we writes r==output_size-1.
  - DONE: done=1 for one cycle, then IDLE.
- Results (any non-IDLE state): acc_valid registers acc_data→out_data and r→out_addr with out_we=1 next cycle; then r++ and outst--. Same-cycle h==0 issue and acc_valid leave outst unchanged.
- acc_valid with outst==0, in IDLE, or after r==output_size: ignored (no out_we), err=1.
- frame_valid while busy: ignored.
- Width rule: w_rd_addr computed as a running base (+hidden_size per neuron) plus h; no multiplier.

## Timing
- Reset: state IDLE; rd_en, mac_valid, mac_first, mac_last, out_we, done, busy, err = 0; all addresses, out_data, and counters = 0; frame_ready=1 once rst deasserts.
- frame_valid at cycle 0 → ISSUE at 1; first rd_en at 1; first mac_valid/mac_first at 2.
- Unstalled frame: output_size*hidden_size consecutive rd_en cycles.
- mac_valid/first/last = rd_en/(h==0)/(h==last) delayed exactly 1 cycle.
- out_we 1 cycle after acc_valid; done 1 cycle after final out_we; frame_ready 1 cycle after done.
- rst mid-frame: immediate return to reset values; partial results discarded; a new frame_valid after reset starts cleanly.

## Test plan
- output_size=4, hidden_size=8, MAX_OUT=2, model returns acc_valid 6 cycles after each mac_last: frame_valid → 32 contiguous rd_en; w_rd_addr 0..31; mac_first at addresses 0,8,16,24; out_addr 0..3 with matching data; done once.
- MAX_OUT=1, acc_valid 20 cycles after mac_last: rd_en gaps before each neuron's h==0 issue; outst never >1; results correct.
- acc_valid coincident with h==0 issue at outst==MAX_OUT-1: outst unchanged, issue proceeds, no stall.
- Spurious acc_valid in IDLE: no out_we, err=1; next frame_valid clears err.
- frame_valid pulsed while busy: ignored, single done, counts unaffected.
- rst asserted at issue #13: all outputs to reset values next edge; following frame_valid produces full correct 32-issue sequence.
